// File: rtl/arb_req_agent.sv
// Requester-side front end for the 5-way, 2-grant rotating-priority arbiter.
// Optional grant legality checking: define ARB_REQ_AGENT_GRANT_CHECK_EN.
module arb_req_agent #(
   parameter int NUM_CLIENTS = 5,
   parameter int CNT_W       = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_CLIENTS-1:0] client_push,
   input  logic                   flush,
   output logic [NUM_CLIENTS-1:0] client_full,
   output logic [NUM_CLIENTS-1:0] client_done,
   output logic [NUM_CLIENTS-1:0] req_out,
   output logic                   req_valid,
   input  logic [NUM_CLIENTS-1:0] grant_in,
   output logic                   busy,
   output logic                   overflow,
   output logic                   grant_err
);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   localparam logic [CNT_W-1:0] MAX = '1;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       pend     [NUM_CLIENTS];
   logic [CNT_W-1:0]       pend_nxt [NUM_CLIENTS];
   logic [NUM_CLIENTS-1:0] pend_nz;
   logic [NUM_CLIENTS-1:0] acc;
   logic [NUM_CLIENTS-1:0] eff_nz;
   logic [NUM_CLIENTS-1:0] ovf_hit;
   logic [NUM_CLIENTS-1:0] req_q;
   logic                   active_live;
   logic                   grant_bad;

   assign active_live = (state == ACTIVE) && !flush;

   always_comb begin
      pend_nz     = '0;
      client_full = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         pend_nz[i]     = (pend[i] != '0);
         client_full[i] = (pend[i] == MAX);
      end
   end

   // A grant only counts in ACTIVE outside the flush cycle; it resolves req_q.
`ifdef ARB_REQ_AGENT_GRANT_CHECK_EN
   logic [NUM_CLIENTS-1:0] bad_bits;
   logic                   too_many;

   always_comb begin
      bad_bits  = grant_in & (~req_q | ~pend_nz);
      too_many  = ($countones(grant_in) > 2);
      acc       = (active_live && !too_many) ? (grant_in & ~bad_bits) : '0;
      grant_bad = active_live && (too_many || (|bad_bits));
   end
`else
   always_comb begin
      acc       = active_live ? grant_in : '0;
      grant_bad = 1'b0;
   end
`endif

   always_comb begin
      eff_nz  = '0;
      ovf_hit = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         logic dec;
         logic inc;
         dec         = acc[i] && pend_nz[i];
         inc         = client_push[i] && !flush && (state != FLUSH);
         pend_nxt[i] = pend[i];
         eff_nz[i]   = ((pend[i] - CNT_W'(dec)) != '0);
         ovf_hit[i]  = inc && client_full[i] && !dec;
         if (flush || state == FLUSH)
            pend_nxt[i] = '0;
         else if (inc && !dec && !client_full[i])
            pend_nxt[i] = pend[i] + CNT_W'(1);
         else if (dec && !inc)
            pend_nxt[i] = pend[i] - CNT_W'(1);
      end
   end

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (flush)             state_nxt = FLUSH;
            else if (|client_push) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (flush)                                state_nxt = FLUSH;
            else if (eff_nz == '0 && client_push == '0) state_nxt = IDLE;
         end
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_valid = (state == ACTIVE);
      req_out   = (state == ACTIVE) ? eff_nz : '0;
      busy      = (state != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments; the small counter array is reset like any register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req_q       <= '0;
         client_done <= '0;
         overflow    <= 1'b0;
         grant_err   <= 1'b0;
         for (int i = 0; i < NUM_CLIENTS; i++) pend[i] <= '0;
      end else begin
         state       <= state_nxt;
         req_q       <= req_out;
         client_done <= acc;
         overflow    <= overflow | (|ovf_hit);
         grant_err   <= grant_err | grant_bad;
         for (int i = 0; i < NUM_CLIENTS; i++) pend[i] <= pend_nxt[i];
      end
   end

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed self-checking bench for arb_req_agent; grant_in is driven by hand
// as the arbiter would return it one cycle after each request.
module tb_arb_req_agent;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] client_push;
   logic       flush;
   logic [4:0] client_full;
   logic [4:0] client_done;
   logic [4:0] req_out;
   logic       req_valid;
   logic [4:0] grant_in;
   logic       busy;
   logic       overflow;
   logic       grant_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   arb_req_agent #(.NUM_CLIENTS(5), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .client_push (client_push),
      .flush       (flush),
      .client_full (client_full),
      .client_done (client_done),
      .req_out     (req_out),
      .req_valid   (req_valid),
      .grant_in    (grant_in),
      .busy        (busy),
      .overflow    (overflow),
      .grant_err   (grant_err)
   );

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic drive(input logic [4:0] p, input logic [4:0] g, input logic f);
      @(negedge clk);
      client_push = p;
      grant_in    = g;
      flush       = f;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(5'($urandom()), 5'b0, 1'b0);
      drive(5'($urandom()), 5'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0; client_push = '0; grant_in = '0; flush = 1'b0; #1;
      n_tests++;
      if ({req_out, req_valid, client_done, client_full, busy, overflow, grant_err} !== 19'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got req=%b vld=%b done=%b full=%b busy=%b ovf=%b gerr=%b exp all 0",
                  req_out, req_valid, client_done, client_full, busy, overflow, grant_err);
      end
      drive(5'b00001, 5'b0, 1'b0);
      drive(5'b00000, 5'b0, 1'b0);
      n_tests++;
      if (req_out !== 5'b00001) begin
         n_fail++; $display("FAIL reset_no_pend req_out got=%b exp=00001", req_out);
      end
      drive(5'b00000, 5'b00001, 1'b0);
      drive(5'b00000, 5'b00000, 1'b0);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_drain busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_basic();
      drive(5'b00111, 5'b0, 1'b0);
      n_tests++;
      if (req_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_c0 req_valid got=%b exp=0", req_valid);
      end
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (req_out !== 5'b00111 || req_valid !== 1'b1) begin
         n_fail++; $display("FAIL basic_c1 req_out/valid got=%b/%b exp=00111/1", req_out, req_valid);
      end
      drive(5'b0, 5'b00011, 1'b0);
      n_tests++;
      if (req_out !== 5'b00100 || client_done !== 5'b0) begin
         n_fail++; $display("FAIL basic_c2 req_out/done got=%b/%b exp=00100/00000", req_out, client_done);
      end
      drive(5'b0, 5'b00100, 1'b0);
      n_tests++;
      if (req_out !== 5'b00000 || client_done !== 5'b00011) begin
         n_fail++; $display("FAIL basic_c3 req_out/done got=%b/%b exp=00000/00011", req_out, client_done);
      end
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (client_done !== 5'b00100 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_c4 done/busy got=%b/%b exp=00100/0", client_done, busy);
      end
   endtask

   task automatic test_no_double_issue();
      int dones;
      dones = 0;
      drive(5'b01000, 5'b0, 1'b0);
      drive(5'b01000, 5'b0, 1'b0);
      n_tests++;
      if (req_out !== 5'b01000) begin
         n_fail++; $display("FAIL nodbl_c1 req_out got=%b exp=01000", req_out);
      end
      drive(5'b0, 5'b01000, 1'b0);
      n_tests++;
      if (req_out !== 5'b01000) begin
         n_fail++; $display("FAIL nodbl_c2 req_out got=%b exp=01000", req_out);
      end
      drive(5'b0, 5'b01000, 1'b0);
      dones += int'(client_done[3]);
      n_tests++;
      if (req_out[3] !== 1'b0) begin
         n_fail++; $display("FAIL nodbl_last_grant req_out[3] got=%b exp=0", req_out[3]);
      end
      drive(5'b0, 5'b0, 1'b0);
      dones += int'(client_done[3]);
      drive(5'b0, 5'b0, 1'b0);
      dones += int'(client_done[3]);
      n_tests++;
      if (dones != 2 || busy !== 1'b0) begin
         n_fail++; $display("FAIL nodbl_done_count got=%0d busy=%b exp=2 busy=0", dones, busy);
      end
   endtask

   task automatic test_push_grant();
      drive(5'b00010, 5'b0, 1'b0);
      drive(5'b00010, 5'b0, 1'b0);
      drive(5'b00010, 5'b00010, 1'b0);
      n_tests++;
      if (req_out !== 5'b00010) begin
         n_fail++; $display("FAIL pg_same_cycle req_out got=%b exp=00010", req_out);
      end
      drive(5'b0, 5'b00010, 1'b0);
      n_tests++;
      if (client_done !== 5'b00010 || req_out !== 5'b00010) begin
         n_fail++; $display("FAIL pg_pend2 done/req got=%b/%b exp=00010/00010", client_done, req_out);
      end
      drive(5'b0, 5'b00010, 1'b0);
      n_tests++;
      if (req_out !== 5'b00000 || client_done !== 5'b00010) begin
         n_fail++; $display("FAIL pg_pend1 req/done got=%b/%b exp=00000/00010", req_out, client_done);
      end
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (client_done !== 5'b00010 || busy !== 1'b0) begin
         n_fail++; $display("FAIL pg_drain done/busy got=%b/%b exp=00010/0", client_done, busy);
      end
   endtask

   task automatic test_flush();
      drive(5'b00010, 5'b0, 1'b0);
      drive(5'b00010, 5'b0, 1'b0);
      drive(5'b00001, 5'b00010, 1'b1);
      drive(5'b00001, 5'b00001, 1'b0);
      n_tests++;
      if (busy !== 1'b1 || req_valid !== 1'b0 || req_out !== 5'b0 || client_done !== 5'b0) begin
         n_fail++;
         $display("FAIL flush_state busy/vld/req/done got=%b/%b/%b/%b exp=1/0/00000/00000",
                  busy, req_valid, req_out, client_done);
      end
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (busy !== 1'b0 || client_done !== 5'b0 || overflow !== 1'b0 || grant_err !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle busy/done/ovf/gerr got=%b/%b/%b/%b exp=0/00000/0/0",
                  busy, client_done, overflow, grant_err);
      end
      drive(5'b00100, 5'b0, 1'b0);
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (req_out !== 5'b00100) begin
         n_fail++; $display("FAIL flush_cleared req_out got=%b exp=00100", req_out);
      end
      drive(5'b0, 5'b00100, 1'b0);
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (client_done !== 5'b00100 || busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_after done/busy got=%b/%b exp=00100/0", client_done, busy);
      end
   endtask

   task automatic test_grant_err();
      drive(5'b00100, 5'b0, 1'b0);
      drive(5'b0, 5'b0, 1'b0);
      drive(5'b0, 5'b00101, 1'b0);
      drive(5'b0, 5'b0, 1'b0);
`ifdef ARB_REQ_AGENT_GRANT_CHECK_EN
      n_tests++;
      if (grant_err !== 1'b1 || client_done !== 5'b00100) begin
         n_fail++; $display("FAIL gerr_set gerr/done got=%b/%b exp=1/00100", grant_err, client_done);
      end
`else
      n_tests++;
      if (grant_err !== 1'b0 || client_done !== 5'b00101) begin
         n_fail++; $display("FAIL gerr_tied gerr/done got=%b/%b exp=0/00101", grant_err, client_done);
      end
`endif
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL gerr_idle busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_saturation();
      logic [4:0] g;
      int         dones;
      for (int k = 0; k < 8; k++) begin
         drive(5'b10000, 5'b0, 1'b0);
         if (k == 6) begin
            n_tests++;
            if (client_full !== 5'b00000) begin
               n_fail++; $display("FAIL sat_6 full got=%b exp=00000", client_full);
            end
         end
         if (k == 7) begin
            n_tests++;
            if (client_full !== 5'b10000 || overflow !== 1'b0) begin
               n_fail++; $display("FAIL sat_7 full/ovf got=%b/%b exp=10000/0", client_full, overflow);
            end
         end
      end
      drive(5'b0, 5'b0, 1'b0);
      n_tests++;
      if (overflow !== 1'b1 || client_full !== 5'b10000 || req_out !== 5'b10000) begin
         n_fail++;
         $display("FAIL sat_drop ovf/full/req got=%b/%b/%b exp=1/10000/10000", overflow, client_full, req_out);
      end
      g     = req_out;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         drive(5'b0, g, 1'b0);
         dones += int'(client_done[4]);
         g = req_out;
      end
      n_tests++;
      if (dones != 7 || busy !== 1'b0 || client_full !== 5'b0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_drain dones=%0d busy=%b full=%b ovf=%b exp dones=7 busy=0 full=00000 ovf=1",
                  dones, busy, client_full, overflow);
      end
   endtask

   task automatic test_sticky_reset();
      @(negedge clk);
      rst = 1'b1; client_push = '0; grant_in = '0; flush = 1'b0;
      @(negedge clk);
      rst = 1'b0; #1;
      n_tests++;
      if (overflow !== 1'b0 || grant_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL sticky_reset ovf/gerr/busy got=%b/%b/%b exp=0/0/0", overflow, grant_err, busy);
      end
   endtask

   initial begin
      rst = 1'b1; client_push = '0; grant_in = '0; flush = 1'b0;
      test_reset();
      test_basic();
      test_no_double_issue();
      test_push_grant();
      test_flush();
      test_grant_err();
      test_saturation();
      test_sticky_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
